// File: rtl/onehot_sequencer.sv
// -----------------------------------------------------------------------------
// onehot_sequencer
//
// Registered one-hot sequencer. It replaces the old combinational 3-to-8
// decoder. A position register (index) drives an always-one-hot output vector
// (onehot == 1 << index). The position can be decoded directly from sel, or it
// can step in one of three ways: rotate up, rotate down, or bounce between the
// two ends. A programmable prescaler sets the step rate.
//
// Parameters
//   SEL_W  width of sel/index; the block has N = 2**SEL_W outputs
//   DIV_W  width of the prescaler divisor
//
// Ports
//   clk     clock
//   rst_n   asynchronous active-low reset
//   ena     block enable; low freezes every state element
//   mode    00 DECODE, 01 ROT_UP, 10 ROT_DOWN, 11 BOUNCE
//   sel     decode select / load value
//   load    synchronous load of sel into index (takes priority over mode)
//   div     prescaler terminal count; one step every div+1 enabled cycles
//   onehot  registered one-hot vector, 1 << index
//   index   current position
//   wrap    one-cycle pulse on a wrap (rotate) or a reversal (bounce)
// -----------------------------------------------------------------------------
module onehot_sequencer #(
   parameter int SEL_W = 3,
   parameter int DIV_W = 16
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    ena,
   input  logic [1:0]              mode,
   input  logic [SEL_W-1:0]        sel,
   input  logic                    load,
   input  logic [DIV_W-1:0]        div,
   output logic [(2**SEL_W)-1:0]   onehot,
   output logic [SEL_W-1:0]        index,
   output logic                    wrap
);

   localparam int N = 2**SEL_W;

   localparam logic [1:0] MODE_DECODE   = 2'b00;
   localparam logic [1:0] MODE_ROT_UP   = 2'b01;
   localparam logic [1:0] MODE_ROT_DOWN = 2'b10;
   localparam logic [1:0] MODE_BOUNCE   = 2'b11;

   localparam logic DIR_UP   = 1'b0;
   localparam logic DIR_DOWN = 1'b1;

   localparam logic [SEL_W-1:0] IDX_MAX = '1;
   localparam logic [SEL_W-1:0] IDX_PEN = IDX_MAX - 1'b1;
   localparam logic [SEL_W-1:0] IDX_ONE = 1;

   logic [SEL_W-1:0] index_q, index_d;
   logic [N-1:0]     onehot_q, onehot_d;
   logic             wrap_q, wrap_d;
   logic [DIV_W-1:0] count_q, count_d;
   logic             dir_q, dir_d;
   logic [1:0]       mode_q, mode_d;  // mode seen on the last enabled cycle
   logic             tick;
   logic             dir_eff;

   // NOTE: every variable gets a default at the top of the block, so no
   // path can leave a value unassigned and no latch is inferred.
   always_comb begin
      index_d  = index_q;
      count_d  = count_q;
      dir_d    = dir_q;
      mode_d   = mode_q;
      wrap_d   = 1'b0;
      tick     = 1'b0;
      dir_eff  = dir_q;

      if (ena) begin
         // A count already above div keeps counting and wraps modulo
         // 2**DIV_W before it can match again.
         tick    = (count_q == div);
         count_d = tick ? '0 : count_q + 1'b1;
         mode_d  = mode;

         // The first cycle in BOUNCE always starts out going up.
         if (mode == MODE_BOUNCE && mode_q != MODE_BOUNCE)
            dir_eff = DIR_UP;
         dir_d = dir_eff;

         if (load) begin
            index_d = sel;
            count_d = '0;
            dir_d   = DIR_UP;
         end else begin
            case (mode)
               MODE_DECODE: index_d = sel;
               MODE_ROT_UP: begin
                  if (tick) begin
                     index_d = index_q + 1'b1;
                     wrap_d  = (index_q == IDX_MAX);
                  end
               end
               MODE_ROT_DOWN: begin
                  if (tick) begin
                     index_d = index_q - 1'b1;
                     wrap_d  = (index_q == '0);
                  end
               end
               default: begin  // MODE_BOUNCE
                  if (tick) begin
                     if (dir_eff == DIR_UP) begin
                        if (index_q == IDX_MAX) begin
                           // Loaded at the top end while heading up: turn
                           // around quietly, with no reversal pulse.
                           index_d = index_q - 1'b1;
                           dir_d   = DIR_DOWN;
                        end else begin
                           index_d = index_q + 1'b1;
                           if (index_q == IDX_PEN) begin
                              dir_d  = DIR_DOWN;
                              wrap_d = 1'b1;
                           end
                        end
                     end else begin
                        if (index_q == '0) begin
                           index_d = index_q + 1'b1;
                           dir_d   = DIR_UP;
                        end else begin
                           index_d = index_q - 1'b1;
                           if (index_q == IDX_ONE) begin
                              dir_d  = DIR_UP;
                              wrap_d = 1'b1;
                           end
                        end
                     end
                  end
               end
            endcase
         end
      end

      onehot_d          = '0;
      onehot_d[index_d] = 1'b1;
   end

   // NOTE: sequential state uses non-blocking assignments only. All
   // registers update together, so their order inside the block does not
   // matter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         index_q  <= '0;
         onehot_q <= {{(N-1){1'b0}}, 1'b1};
         wrap_q   <= 1'b0;
         count_q  <= '0;
         dir_q    <= DIR_UP;
         mode_q   <= MODE_DECODE;
      end else begin
         index_q  <= index_d;
         onehot_q <= onehot_d;
         wrap_q   <= wrap_d;
         count_q  <= count_d;
         dir_q    <= dir_d;
         mode_q   <= mode_d;
      end
   end

   assign index  = index_q;
   assign onehot = onehot_q;
   assign wrap   = wrap_q;

endmodule

// File: tb/tb_onehot_sequencer.sv
// -----------------------------------------------------------------------------
// tb_onehot_sequencer
//
// Self-checking bench for onehot_sequencer with SEL_W=3 and DIV_W=16. It runs
// a table of single-cycle vectors, then hand-written multi-cycle sequences,
// then randomized cycles checked against a behavioural model. The model
// describes the bounce motion as a phase on a 2N-2 step ring.
// -----------------------------------------------------------------------------
module tb_onehot_sequencer;

   localparam int SEL_W = 3;
   localparam int DIV_W = 16;
   localparam int N     = 2**SEL_W;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             ena = 1'b0;
   logic [1:0]       mode = 2'b00;
   logic [SEL_W-1:0] sel = '0;
   logic             load = 1'b0;
   logic [DIV_W-1:0] div = '0;
   logic [N-1:0]     onehot;
   logic [SEL_W-1:0] index;
   logic             wrap;

   int n_checks = 0;
   int n_pass   = 0;

   onehot_sequencer #(.SEL_W(SEL_W), .DIV_W(DIV_W)) dut (
      .clk(clk), .rst_n(rst_n), .ena(ena), .mode(mode), .sel(sel),
      .load(load), .div(div), .onehot(onehot), .index(index), .wrap(wrap)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
   endtask

   // Checks all three outputs against an expected position and wrap value.
   task automatic check_state(input string name, input int exp_idx, input bit exp_wrap);
      logic [N-1:0] exp_oh;
      exp_oh = '0;
      exp_oh[exp_idx] = 1'b1;
      check({name, ".index"},  32'(index),  32'(exp_idx));
      check({name, ".onehot"}, 32'(onehot), 32'(exp_oh));
      check({name, ".wrap"},   32'(wrap),   32'(exp_wrap));
   endtask

   // One clock: inputs already driven; sample 1 time unit after the edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // ---------------------------------------------------------------- vectors
   typedef struct {
      logic       ena;
      logic [1:0] mode;
      int         sel;
      logic       load;
      int         div;
      int         exp_idx;
      bit         exp_wrap;
   } vec_t;

   vec_t vecs[$];

   // ---------------------------------------------------------- reference model
   int m_idx, m_cnt, m_phase;
   logic [1:0] m_prev_mode;
   bit m_wrap;

   task automatic model_reset();
      m_idx = 0; m_cnt = 0; m_phase = 0; m_prev_mode = 2'b00; m_wrap = 0;
   endtask

   task automatic model_cycle();
      bit tick;
      m_wrap = 0;
      if (!ena) return;
      tick  = (m_cnt == int'(div));
      m_cnt = tick ? 0 : (m_cnt + 1) % (1 << DIV_W);
      if (mode == 2'b11 && m_prev_mode != 2'b11) m_phase = m_idx;
      m_prev_mode = mode;
      if (load) begin
         m_idx = int'(sel); m_cnt = 0; m_phase = int'(sel);
      end else begin
         case (mode)
            2'b00: m_idx = int'(sel);
            2'b01: if (tick) begin m_wrap = (m_idx == N-1); m_idx = (m_idx + 1) % N; end
            2'b10: if (tick) begin m_wrap = (m_idx == 0); m_idx = (m_idx + N - 1) % N; end
            default: if (tick) begin
               m_phase = (m_phase + 1) % (2*N - 2);
               m_idx   = (m_phase < N) ? m_phase : 2*N - 2 - m_phase;
               m_wrap  = (m_phase == N-1) || (m_phase == 0);
            end
         endcase
      end
   endtask

   initial begin
      // ---------------------------------------------------------- reset
      repeat (3) @(posedge clk);
      #1;
      check_state("in_reset", 0, 0);
      rst_n = 1'b1;
      ena   = 1'b1;
      #1;
      check_state("reset_release", 0, 0);

      // ---------------------------------------------------------- table
      for (int i = 0; i < 8; i++) vecs.push_back('{1, 2'b00, i, 0, 0, i, 0});
      vecs.push_back('{1, 2'b10, 1, 1, 0, 1, 0});  // load 1 in ROT_DOWN
      vecs.push_back('{1, 2'b10, 0, 0, 0, 0, 0});
      vecs.push_back('{1, 2'b10, 0, 0, 0, 7, 1});  // 0 -> 7 wraps
      vecs.push_back('{0, 2'b10, 0, 0, 0, 7, 0});  // disabled: hold, wrap 0
      vecs.push_back('{1, 2'b10, 0, 0, 0, 6, 0});
      vecs.push_back('{1, 2'b10, 3, 1, 0, 3, 0});  // load beats tick
      vecs.push_back('{1, 2'b10, 0, 0, 0, 2, 0});
      vecs.push_back('{0, 2'b01, 0, 0, 0, 2, 0});
      vecs.push_back('{1, 2'b01, 0, 0, 0, 3, 0});
      foreach (vecs[i]) begin
         ena  = vecs[i].ena;
         mode = vecs[i].mode;
         sel  = SEL_W'(vecs[i].sel);
         load = vecs[i].load;
         div  = DIV_W'(vecs[i].div);
         step();
         check_state($sformatf("vec%0d", i), vecs[i].exp_idx, vecs[i].exp_wrap);
      end

      // ------------------------------------------------ ROT_UP, div=2
      ena = 1; mode = 2'b01; div = 2; sel = 0; load = 1;
      step();
      load = 0;
      for (int k = 1; k <= 24; k++) begin
         step();
         check_state($sformatf("rotup_k%0d", k), (k/3) % N, (k % 3 == 0) && ((k/3) % N == 0));
      end

      // ------------------------------------------------ BOUNCE, div=0
      mode = 2'b11; div = 0; sel = 0; load = 1;
      step();
      load = 0;
      for (int k = 1; k <= 15; k++) begin
         int p;
         p = k % (2*N - 2);
         step();
         check_state($sformatf("bounce_k%0d", k), (p < N) ? p : 2*N - 2 - p, (p == N-1) || (p == 0));
         check("bounce_popcount", 32'($countones(onehot)), 32'd1);
      end
      sel = 3'd7; load = 1;
      step();
      check_state("bounce_load7", 7, 0);
      load = 0;
      step();
      check_state("bounce_top_turn", 6, 0);
      step();
      check_state("bounce_after_turn", 5, 0);

      // ------------------------------------- ena freeze, ROT_UP, div=3
      mode = 2'b01; div = 3; sel = 0; load = 1;
      step();
      load = 0;
      step(); step();                 // prescaler count now 2
      ena = 0;
      for (int k = 0; k < 5; k++) begin
         step();
         check_state($sformatf("frozen_k%0d", k), 0, 0);
      end
      ena = 1;
      step();
      check_state("resume_no_tick", 0, 0);
      step();
      check_state("resume_tick", 1, 0);

      // ------------------------------------- async reset mid-rotation
      mode = 2'b01; div = 0; sel = 2; load = 1;
      step();
      load = 0;
      step();
      check_state("pre_async", 3, 0);
      @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      check_state("async_reset", 0, 0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // ---------------------------------------------------------- random
      model_reset();
      for (int c = 0; c < 3000; c++) begin
         if (c % 60 == 0) div = DIV_W'($urandom_range(0, 3));
         ena  = ($urandom_range(0, 7) != 0);
         mode = 2'($urandom_range(0, 3));
         sel  = SEL_W'($urandom_range(0, N-1));
         load = ($urandom_range(0, 9) == 0);
         model_cycle();
         step();
         check_state("random", m_idx, m_wrap);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/onehot_sequencer.md
Name: onehot_sequencer

Overview:
- Parametrised successor to the team's combinational 3-to-8 one-hot decoder.
- Produces a registered, always-one-hot output vector of width N, driven by a state register.
- Four modes: direct decode of a select input, rotate up, rotate down, and bounce (ping-pong).
- Stepping is paced by a programmable prescaler; the block drives LED/enable banks from the dedicated I/O of the top-level wrapper.

Parameters:
- SEL_W, 3, width of select/index; N = 2**SEL_W outputs.
- DIV_W, 16, width of prescaler divisor.

Ports:
- clk  input  1  clock
- rst_n  input  1  asynchronous active-low reset
- ena  input  1  block enable; low freezes all state
- mode  input  2  00 DECODE, 01 ROT_UP, 10 ROT_DOWN, 11 BOUNCE
- sel  input  SEL_W  decode select / load value
- load  input  1  synchronous load of sel into index
- div  input  DIV_W  prescaler terminal count; step every div+1 enabled cycles
- onehot  output  N  registered one-hot vector, equal to 1<<index
- index  output  SEL_W  current position
- wrap  output  1  one-cycle pulse on wrap or reversal

Behaviour:
- Reset (async, rst_n=0):
  - index=0, onehot={0..,1} (bit0 set), wrap=0.
  - Prescaler count=0, direction=up.
  - All outputs registered and defined during reset.
- Invariant: exactly one bit of onehot is set at all times; onehot == 1<<index, registered in the same cycle as index.
- ena=0: index, onehot, prescaler count and direction hold; wrap forced 0 the next cycle.
- Prescaler (ena=1):
  - If count==div, tick=1 and count<=0; else count<=count+1.
  - div=0 gives a tick every cycle.
  - div changed mid-count: compare uses the current div; if count>div, count keeps incrementing and wraps modulo 2**DIV_W.
- Priority per enabled cycle: load > mode action.
- load=1:
  - index<=sel, count<=0, direction<=up, wrap<=0.
  - Applies in every mode.
- DECODE:
  - index<=sel every enabled cycle; latency 1 cycle from sel to onehot.
  - Prescaler runs but is ignored; wrap=0.
- ROT_UP, on tick:
  - index<=index+1.
  - N-1 -> 0 wraps and wrap=1 for that cycle.
- ROT_DOWN, on tick:
  - index<=index-1.
  - 0 -> N-1 wraps and wrap=1.
- BOUNCE, on tick:
  - Direction up: index+1. On reaching N-1, direction<=down and wrap=1 in the cycle index becomes N-1.
  - Direction down: index-1. On reaching 0, direction<=up and wrap=1.
  - Entering BOUNCE from another mode forces direction<=up on the first cycle in BOUNCE.
  - If index==N-1 and direction==up at a tick (after a load), it steps to N-2 and sets direction down; no wrap pulse.
- wrap:
  - Registered; high for exactly one clk cycle per event.
  - Never high without an index change in the same cycle.
- Mode change mid-count: prescaler not cleared; the new mode acts on the next tick; index is retained (DECODE overwrites it next cycle).
- Reset asserted mid-operation: immediate return to reset values regardless of clk.
- Implementation: single always block with async reset for state; no latches; no combinational path from inputs to outputs.

Test Plan:
- Reset with rst_n=0 while clk runs, release -> onehot=8'h01, index=0, wrap=0; assert rst_n=0 mid-rotation -> outputs return to 8'h01 within the same cycle, before the next edge.
- DECODE, sel swept 0..7 one per cycle -> onehot = 8'h01, 02, 04 ... 80, each one cycle after sel; wrap stays 0.
- ROT_UP, div=2 -> index advances every 3 cycles, 0..7 then 0; wrap=1 only on the 7->0 step; onehot 8'h80->8'h01.
- ROT_DOWN, div=0, load sel=1 -> index 1,0,7,6...; wrap pulses on 0->7; load asserted in the same cycle as a tick -> index=sel, no step.
- BOUNCE, div=0 from index 0 -> index 0,1..7,6..0,1; wrap pulses at index 7 and at index 0; onehot always has popcount 1.
- ena toggled low for 5 cycles during ROT_UP, div=3 -> index and prescaler frozen; stepping resumes with the same phase after ena returns high.
